// File: rtl/olink_rx_framer.sv
// ---------------------------------------------------------------------------
// olink_rx_framer
// Receive framer for the optical link, in the clk_link domain after the GTX
// RX data port. It gathers RATIO GTX words into one comma-aligned output
// word, using a HUNT/VERIFY/LOCKED alignment FSM. It also keeps saturating
// nit/comma counters and a triggered spy capture buffer.
//
// Ports
//   clk_link, reset            link clock, synchronous active-high reset
//   rx_d_i/rx_k_i/rx_nit_i     GTX RX data, charisk, not-in-table
//   rx_reset_done              GTX RX reset complete; low forces HUNT
//   rx_d/rx_k                  assembled word (slot 0 in LSBs), held
//   rx_v/rx_err                1-cycle strobes for clean/bad word in LOCKED
//   locked                     alignment FSM is in LOCKED
//   cnt_clear                  clears bad_count and comma_count
//   bad_count/comma_count      saturating event counters
//   spy_mode/spy_arm           trigger select and arm pulse for the spy
//   spy_done                   spy buffer filled
//   spy_raddr/spy_rdata        spy read port, one cycle of latency
// ---------------------------------------------------------------------------
module olink_rx_framer #(
    parameter int unsigned IN_BYTES    = 2,
    parameter int unsigned RATIO       = 2,
    parameter int unsigned LOCK_COUNT  = 4,
    parameter int unsigned UNLOCK_ERRS = 8,
    parameter int unsigned SPY_AW      = 6
) (
    input  logic                         clk_link,
    input  logic                         reset,
    input  logic [8*IN_BYTES-1:0]        rx_d_i,
    input  logic [IN_BYTES-1:0]          rx_k_i,
    input  logic [IN_BYTES-1:0]          rx_nit_i,
    input  logic                         rx_reset_done,
    output logic [8*IN_BYTES*RATIO-1:0]  rx_d,
    output logic [IN_BYTES*RATIO-1:0]    rx_k,
    output logic                         rx_v,
    output logic                         rx_err,
    output logic                         locked,
    input  logic                         cnt_clear,
    output logic [31:0]                  bad_count,
    output logic [31:0]                  comma_count,
    input  logic [1:0]                   spy_mode,
    input  logic                         spy_arm,
    output logic                         spy_done,
    input  logic [SPY_AW-1:0]            spy_raddr,
    output logic [10*IN_BYTES-1:0]       spy_rdata
);

    localparam int unsigned IW        = 8 * IN_BYTES;
    localparam int unsigned OW        = IW * RATIO;
    localparam int unsigned KW        = IN_BYTES * RATIO;
    localparam int unsigned SW        = 10 * IN_BYTES;
    localparam int unsigned PH_W      = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int unsigned VC_W      = $clog2(LOCK_COUNT + 1);
    localparam int unsigned EC_W      = $clog2(UNLOCK_ERRS + 1);
    localparam int unsigned SPY_DEPTH = 1 << SPY_AW;

    localparam logic [PH_W-1:0]     PH_LAST = PH_W'(RATIO - 1);
    localparam logic [IN_BYTES-1:0] K_LANE0 = IN_BYTES'(1);
    localparam logic [31:0]         CNT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SP_IDLE  = 2'd0,
        SP_ARMED = 2'd1,
        SP_CAPT  = 2'd2
    } spy_state_t;

    // ---------------- framer state ----------------
    state_t                r_state;
    state_t                w_state_nxt;
    logic [PH_W-1:0]       r_ph;
    logic [VC_W-1:0]       r_vcnt;
    logic [VC_W-1:0]       w_vcnt_nxt;
    logic [EC_W-1:0]       r_errrun;
    logic [EC_W-1:0]       w_errrun_nxt;
    logic                  r_bad_acc;
    logic [IW-1:0]         r_slot_d [RATIO];
    logic [IN_BYTES-1:0]   r_slot_k [RATIO];
    logic [OW-1:0]         r_rx_d;
    logic [KW-1:0]         r_rx_k;
    logic                  r_rx_v;
    logic                  r_rx_err;
    logic                  r_locked;

    logic                  w_comma;
    logic                  w_nit;
    logic                  w_hunt_comma;
    logic [PH_W-1:0]       w_wr_slot;
    logic [PH_W-1:0]       w_ph_nxt;
    logic                  w_slot_bad;
    logic                  w_word_bad;
    logic                  w_word_end;
    logic                  w_v_nxt;
    logic                  w_err_nxt;
    logic [OW-1:0]         w_word_d;
    logic [KW-1:0]         w_word_k;

    // ---------------- counters ----------------
    logic [31:0]           r_bad_count;
    logic [31:0]           r_comma_count;

    // ---------------- spy ----------------
    spy_state_t            r_spy_state;
    spy_state_t            w_spy_state_nxt;
    logic [SPY_AW-1:0]     r_spy_ptr;
    logic [SPY_AW-1:0]     w_spy_ptr_nxt;
    logic                  r_spy_done;
    logic                  w_spy_done_nxt;
    logic                  w_spy_we;
    logic                  w_spy_trig;
    logic [SW-1:0]         r_spy_mem [SPY_DEPTH];
    logic [SW-1:0]         r_spy_rdata;

    // Comma: lane 0 is K28.5 and no other lane carries a control character.
    assign w_comma = (rx_k_i == K_LANE0) && (rx_d_i[7:0] == 8'hBC);
    assign w_nit   = |rx_nit_i;

    // A comma seen while hunting re-aligns: it is written to slot 0.
    assign w_hunt_comma = (r_state == ST_HUNT) && w_comma && rx_reset_done;
    assign w_wr_slot    = w_hunt_comma ? '0 : r_ph;
    assign w_ph_nxt     = (w_wr_slot == PH_LAST) ? '0 : w_wr_slot + PH_W'(1);
    assign w_word_end   = (w_wr_slot == PH_LAST);

    // Word quality accumulates across slots and restarts at slot 0.
    assign w_slot_bad = w_nit || (w_comma && (w_wr_slot != '0));
    assign w_word_bad = ((w_wr_slot == '0) ? 1'b0 : r_bad_acc) || w_slot_bad;

    // Completed word: stored slots plus the word arriving in the last slot.
    always_comb begin
        w_word_d = '0;
        w_word_k = '0;
        for (int unsigned i = 0; i < RATIO - 1; i++) begin
            w_word_d[i*IW +: IW]             = r_slot_d[i];
            w_word_k[i*IN_BYTES +: IN_BYTES] = r_slot_k[i];
        end
        w_word_d[(RATIO-1)*IW +: IW]             = rx_d_i;
        w_word_k[(RATIO-1)*IN_BYTES +: IN_BYTES] = rx_k_i;
    end

    // Alignment FSM next state and word strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_vcnt_nxt   = r_vcnt;
        w_errrun_nxt = r_errrun;
        w_v_nxt      = 1'b0;
        w_err_nxt    = 1'b0;
        unique case (r_state)
            ST_HUNT: begin
                if (w_comma) begin
                    w_state_nxt = ST_VERIFY;
                    w_vcnt_nxt  = VC_W'(1);
                end
            end
            ST_VERIFY: begin
                if (w_nit || (w_comma && (r_ph != '0))) begin
                    w_state_nxt = ST_HUNT;
                end else if (w_comma) begin
                    if (r_vcnt == VC_W'(LOCK_COUNT - 1)) begin
                        w_state_nxt  = ST_LOCKED;
                        w_errrun_nxt = '0;
                    end
                    w_vcnt_nxt = r_vcnt + VC_W'(1);
                end
            end
            ST_LOCKED: begin
                if (w_word_end) begin
                    if (w_word_bad) begin
                        w_err_nxt = 1'b1;
                        if (r_errrun == EC_W'(UNLOCK_ERRS - 1)) begin
                            w_state_nxt = ST_HUNT;
                        end
                        w_errrun_nxt = r_errrun + EC_W'(1);
                    end else begin
                        w_v_nxt      = 1'b1;
                        w_errrun_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
        // Loss of the transceiver overrides everything.
        if (!rx_reset_done) begin
            w_state_nxt = ST_HUNT;
            w_v_nxt     = 1'b0;
            w_err_nxt   = 1'b0;
        end
    end

    // Alignment FSM and output registers.
    always_ff @(posedge clk_link) begin
        if (reset) begin
            r_state   <= ST_HUNT;
            r_ph      <= '0;
            r_vcnt    <= '0;
            r_errrun  <= '0;
            r_bad_acc <= 1'b0;
            r_rx_d    <= '0;
            r_rx_k    <= '0;
            r_rx_v    <= 1'b0;
            r_rx_err  <= 1'b0;
            r_locked  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ph      <= w_ph_nxt;
            r_vcnt    <= w_vcnt_nxt;
            r_errrun  <= w_errrun_nxt;
            r_bad_acc <= w_word_bad;
            r_rx_v    <= w_v_nxt;
            r_rx_err  <= w_err_nxt;
            r_locked  <= (w_state_nxt == ST_LOCKED);
            if (w_v_nxt || w_err_nxt) begin
                r_rx_d <= w_word_d;
                r_rx_k <= w_word_k;
            end
        end
    end

    // Slot storage; contents only matter once a full word has been gathered.
    always_ff @(posedge clk_link) begin
        r_slot_d[w_wr_slot] <= rx_d_i;
        r_slot_k[w_wr_slot] <= rx_k_i;
    end

    // Saturating counters; clear has priority over an increment.
    always_ff @(posedge clk_link) begin
        if (reset || cnt_clear) begin
            r_bad_count   <= '0;
            r_comma_count <= '0;
        end else begin
            if (w_nit && (r_bad_count != CNT_MAX)) begin
                r_bad_count <= r_bad_count + 32'(1);
            end
            if (w_comma && (r_comma_count != CNT_MAX)) begin
                r_comma_count <= r_comma_count + 32'(1);
            end
        end
    end

    // Spy trigger select; mode 3 behaves like immediate.
    always_comb begin
        unique case (spy_mode)
            2'd1:    w_spy_trig = w_comma;
            2'd2:    w_spy_trig = w_nit;
            default: w_spy_trig = 1'b1;
        endcase
    end

    // Spy FSM next state; arm restarts from any state.
    always_comb begin
        w_spy_state_nxt = r_spy_state;
        w_spy_ptr_nxt   = r_spy_ptr;
        w_spy_done_nxt  = r_spy_done;
        w_spy_we        = 1'b0;
        if (spy_arm) begin
            w_spy_state_nxt = SP_ARMED;
            w_spy_ptr_nxt   = '0;
            w_spy_done_nxt  = 1'b0;
        end else begin
            unique case (r_spy_state)
                SP_IDLE: begin
                end
                SP_ARMED: begin
                    if (w_spy_trig) begin
                        w_spy_we        = 1'b1;
                        w_spy_ptr_nxt   = r_spy_ptr + SPY_AW'(1);
                        w_spy_state_nxt = SP_CAPT;
                    end
                end
                SP_CAPT: begin
                    w_spy_we      = 1'b1;
                    w_spy_ptr_nxt = r_spy_ptr + SPY_AW'(1);
                    if (r_spy_ptr == {SPY_AW{1'b1}}) begin
                        w_spy_state_nxt = SP_IDLE;
                        w_spy_done_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_spy_state_nxt = SP_IDLE;
                end
            endcase
        end
    end

    // Spy FSM registers.
    always_ff @(posedge clk_link) begin
        if (reset) begin
            r_spy_state <= SP_IDLE;
            r_spy_ptr   <= '0;
            r_spy_done  <= 1'b0;
        end else begin
            r_spy_state <= w_spy_state_nxt;
            r_spy_ptr   <= w_spy_ptr_nxt;
            r_spy_done  <= w_spy_done_nxt;
        end
    end

    // Spy RAM write; the pointer is 0 on the trigger cycle.
    always_ff @(posedge clk_link) begin
        if (w_spy_we) begin
            r_spy_mem[r_spy_ptr] <= {rx_nit_i, rx_k_i, rx_d_i};
        end
    end

    // Registered spy read port.
    always_ff @(posedge clk_link) begin
        if (reset) begin
            r_spy_rdata <= '0;
        end else begin
            r_spy_rdata <= r_spy_mem[spy_raddr];
        end
    end

    assign rx_d        = r_rx_d;
    assign rx_k        = r_rx_k;
    assign rx_v        = r_rx_v;
    assign rx_err      = r_rx_err;
    assign locked      = r_locked;
    assign bad_count   = r_bad_count;
    assign comma_count = r_comma_count;
    assign spy_done    = r_spy_done;
    assign spy_rdata   = r_spy_rdata;

endmodule

// File: tb/tb_olink_rx_framer.sv
// ---------------------------------------------------------------------------
// tb_olink_rx_framer
// Directed bench for olink_rx_framer with IN_BYTES=2, RATIO=2: lock, word
// assembly, unlock on error runs, misaligned comma in VERIFY, rx_reset_done
// and reset while locked, counters with clear and saturation, nit-triggered
// spy capture and readback.
// ---------------------------------------------------------------------------
module tb_olink_rx_framer;

    localparam int unsigned IN_BYTES    = 2;
    localparam int unsigned RATIO       = 2;
    localparam int unsigned LOCK_COUNT  = 4;
    localparam int unsigned UNLOCK_ERRS = 8;
    localparam int unsigned SPY_AW      = 6;

    logic        clk_link = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] rx_d_i = '0;
    logic [1:0]  rx_k_i = '0;
    logic [1:0]  rx_nit_i = '0;
    logic        rx_reset_done = 1'b0;
    logic [31:0] rx_d;
    logic [3:0]  rx_k;
    logic        rx_v;
    logic        rx_err;
    logic        locked;
    logic        cnt_clear = 1'b0;
    logic [31:0] bad_count;
    logic [31:0] comma_count;
    logic [1:0]  spy_mode = 2'd0;
    logic        spy_arm = 1'b0;
    logic        spy_done;
    logic [5:0]  spy_raddr = '0;
    logic [19:0] spy_rdata;

    int n_checks = 0;
    int n_err    = 0;
    int exp_comma = 0;
    int exp_bad   = 0;

    olink_rx_framer #(
        .IN_BYTES   (IN_BYTES),
        .RATIO      (RATIO),
        .LOCK_COUNT (LOCK_COUNT),
        .UNLOCK_ERRS(UNLOCK_ERRS),
        .SPY_AW     (SPY_AW)
    ) dut (
        .clk_link     (clk_link),
        .reset        (reset),
        .rx_d_i       (rx_d_i),
        .rx_k_i       (rx_k_i),
        .rx_nit_i     (rx_nit_i),
        .rx_reset_done(rx_reset_done),
        .rx_d         (rx_d),
        .rx_k         (rx_k),
        .rx_v         (rx_v),
        .rx_err       (rx_err),
        .locked       (locked),
        .cnt_clear    (cnt_clear),
        .bad_count    (bad_count),
        .comma_count  (comma_count),
        .spy_mode     (spy_mode),
        .spy_arm      (spy_arm),
        .spy_done     (spy_done),
        .spy_raddr    (spy_raddr),
        .spy_rdata    (spy_rdata)
    );

    always #5 clk_link = ~clk_link;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One link cycle: drive inputs, clock, then sample 1 ns after the edge.
    task automatic cyc(input logic [15:0] d, input logic [1:0] k, input logic [1:0] nit);
        rx_d_i   = d;
        rx_k_i   = k;
        rx_nit_i = nit;
        @(posedge clk_link);
        if (reset || cnt_clear) begin
            exp_comma = 0;
            exp_bad   = 0;
        end else begin
            if (k == 2'b01 && d[7:0] == 8'hBC) exp_comma++;
            if (nit != 2'b00) exp_bad++;
        end
        #1;
        spy_arm   = 1'b0;
        cnt_clear = 1'b0;
    endtask

    task automatic comma();
        cyc(16'h50BC, 2'b01, 2'b00);
    endtask

    task automatic data(input logic [1:0] nit);
        cyc(16'h1234, 2'b00, nit);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        cyc(16'h0000, 2'b00, 2'b00);
        cyc(16'h0000, 2'b00, 2'b00);
        chk("rst_rx_d", rx_d, 32'h0);
        chk("rst_rx_k", rx_k, 4'h0);
        chk("rst_rx_v", rx_v, 1'b0);
        chk("rst_rx_err", rx_err, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_bad", bad_count, 32'h0);
        chk("rst_comma", comma_count, 32'h0);
        chk("rst_spy_done", spy_done, 1'b0);
        chk("rst_spy_rdata", spy_rdata, 20'h0);
        reset = 1'b0;
        rx_reset_done = 1'b1;

        // Lock on the 4th aligned comma
        for (int i = 0; i < 3; i++) begin
            comma();
            data(2'b00);
        end
        chk("lock_not_yet", locked, 1'b0);
        chk("no_v_verify", rx_v, 1'b0);
        comma();
        chk("lock_after_4", locked, 1'b1);
        chk("no_v_on_comma", rx_v, 1'b0);
        data(2'b00);
        chk("first_v", rx_v, 1'b1);
        chk("first_err", rx_err, 1'b0);
        chk("first_d", rx_d, 32'h1234_50BC);
        chk("first_k", rx_k, 4'b0001);
        comma();
        chk("v_gap", rx_v, 1'b0);
        chk("d_hold", rx_d, 32'h1234_50BC);
        data(2'b00);
        chk("second_v", rx_v, 1'b1);
        chk("comma_cnt5", comma_count, 32'd5);
        chk("bad_cnt0", bad_count, 32'd0);

        // 7 bad words then a clean one keeps lock
        for (int i = 0; i < 7; i++) begin
            comma();
            data(2'b01);
            chk("err7_pulse", rx_err, 1'b1);
            chk("err7_locked", locked, 1'b1);
        end
        comma();
        data(2'b00);
        chk("clean_after7_v", rx_v, 1'b1);
        chk("clean_after7_locked", locked, 1'b1);

        // 8 consecutive bad words drop lock on the 8th
        for (int i = 0; i < 8; i++) begin
            comma();
            data(2'b01);
            chk("err8_pulse", rx_err, 1'b1);
            chk("err8_no_v", rx_v, 1'b0);
            chk("err8_locked", locked, (i < 7) ? 1'b1 : 1'b0);
        end
        chk("bad_cnt15", bad_count, 32'd15);
        chk("comma_cnt_model", comma_count, exp_comma);

        // Misaligned comma in VERIFY returns to HUNT
        comma();
        data(2'b00);
        comma();
        comma();
        chk("misalign_unlocked", locked, 1'b0);
        for (int i = 0; i < 3; i++) begin
            comma();
            data(2'b00);
        end
        chk("relock_not_yet", locked, 1'b0);
        comma();
        chk("relock", locked, 1'b1);
        data(2'b00);
        chk("relock_v", rx_v, 1'b1);
        chk("relock_d", rx_d, 32'h1234_50BC);

        // rx_reset_done low while locked
        rx_reset_done = 1'b0;
        comma();
        chk("rrd_unlock", locked, 1'b0);
        rx_reset_done = 1'b1;
        data(2'b00);
        chk("rrd_no_v", rx_v, 1'b0);
        comma();
        data(2'b00);
        chk("rrd_no_v2", rx_v, 1'b0);
        for (int i = 0; i < 3; i++) begin
            comma();
            data(2'b00);
        end
        chk("rrd_relock", locked, 1'b1);
        chk("rrd_relock_v", rx_v, 1'b1);

        // Reset while locked
        reset = 1'b1;
        comma();
        chk("rst2_locked", locked, 1'b0);
        chk("rst2_rx_d", rx_d, 32'h0);
        chk("rst2_rx_v", rx_v, 1'b0);
        chk("rst2_comma", comma_count, 32'h0);
        reset = 1'b0;
        data(2'b00);
        chk("rst2_no_v", rx_v, 1'b0);
        comma();
        data(2'b00);
        chk("rst2_no_v2", rx_v, 1'b0);

        // Counters: three nit cycles, clear beats increment, saturation
        for (int i = 0; i < 3; i++) data(2'b10);
        chk("bad3", bad_count, 32'd3);
        cnt_clear = 1'b1;
        data(2'b01);
        chk("clr_wins", bad_count, 32'd0);
        chk("clr_comma", comma_count, 32'd0);
        force dut.r_bad_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_bad_count;
        data(2'b01);
        chk("bad_sat", bad_count, 32'hFFFF_FFFF);

        // Spy: nit trigger 10 cycles after arm
        spy_mode = 2'd2;
        spy_arm  = 1'b1;
        data(2'b00);
        for (int i = 0; i < 9; i++) cyc(16'h0F0F, 2'b00, 2'b00);
        cyc(16'hA55A, 2'b00, 2'b10);
        chk("spy_trig_not_done", spy_done, 1'b0);
        for (int i = 0; i < 62; i++) data(2'b00);
        chk("spy_not_done_63", spy_done, 1'b0);
        data(2'b00);
        chk("spy_done_64", spy_done, 1'b1);
        spy_raddr = 6'd0;
        data(2'b00);
        chk("spy_e0", spy_rdata, 20'h8A55A);
        spy_raddr = 6'd1;
        #1;
        chk("spy_rd_latency", spy_rdata, 20'h8A55A);
        data(2'b00);
        chk("spy_e1", spy_rdata, 20'h01234);
        spy_raddr = 6'd63;
        data(2'b00);
        chk("spy_e63", spy_rdata, 20'h01234);
        chk("spy_done_hold", spy_done, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
